// File: rtl/proj_pkg.sv
// Shared definitions for the perspective projector: FSM states, flag bit positions
// and default parameter values.
package proj_pkg;

  localparam int W_DEF      = 32;
  localparam int NEAR_DEF   = 1;

  localparam int FLG_DIVZ   = 0;
  localparam int FLG_BEHIND = 1;
  localparam int FLG_SAT    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/proj_div.sv
// Iterative unsigned restoring divider: one quotient bit per edge, 2W iterations.
// The quotient/done outputs present the result of the step being taken this cycle.
module proj_div #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [2*W-1:0] quotient,
  output logic           done
);

  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  logic [2*W-1:0] dq;
  logic [W-1:0]   rem;
  logic [W-1:0]   dv;
  logic [CW-1:0]  cnt;
  logic           busy;

  logic [W:0]     trial;
  logic           ge;
  logic [W-1:0]   rem_n;

  // Dividend bits shift into the partial remainder while quotient bits shift in behind.
  assign trial    = {rem, dq[2*W-1]};
  assign ge       = (trial >= {1'b0, dv});
  assign rem_n    = W'(ge ? (trial - {1'b0, dv}) : trial);
  assign quotient = {dq[2*W-2:0], ge};
  assign done     = busy && (cnt == LAST);

  // Iteration state: loaded on start, advanced once per edge while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq   <= {(2*W){1'b0}};
      rem  <= {W{1'b0}};
      dv   <= {W{1'b0}};
      cnt  <= {CW{1'b0}};
      busy <= 1'b0;
    end else if (start) begin
      dq   <= dividend;
      rem  <= {W{1'b0}};
      dv   <= divisor;
      cnt  <= {CW{1'b0}};
      busy <= 1'b1;
    end else if (busy) begin
      dq   <= quotient;
      rem  <= rem_n;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/perspective_projector.sv
// Perspective projection ox = x*d/z, oy = y*d/z with fixed 2W+1 edge latency.
// Optional viewport offset (cx, cy) enabled by macro PROJ_VIEWPORT_EN.
module perspective_projector
  import proj_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NEAR = NEAR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic [W-1:0] d,
`ifdef PROJ_VIEWPORT_EN
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ox,
  output logic [W-1:0] oy,
  output logic [2:0]   flags
);

  localparam logic signed [2*W+1:0] MAXV = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W+1:0] MINV = {{(W+3){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]   NEAR_W = W'(NEAR);

  state_t                state;
  logic [W-1:0]          xr, yr, zr, dr;
  logic signed [2*W-1:0] px, py;
  logic [2*W-1:0]        mag_x, mag_y, qx, qy;
  logic [W-1:0]          mag_z, off_x, off_y;
  logic [W:0]            res_x, res_y;
  logic                  done_x, done_y, div_start, z_zero, behind;

  // Apply the sign, add the offset and clamp to the W-bit signed range; MSB is the sat flag.
  function automatic logic [W:0] sat_result(input logic [2*W-1:0] mag, input logic neg,
                                            input logic [W-1:0] off);
    logic signed [2*W+1:0] v;
    v = $signed({2'b00, mag});
    if (neg) v = -v;
    v = v + $signed({{(W+2){off[W-1]}}, off});
    if (v > MAXV)      sat_result = {1'b1, MAXV[W-1:0]};
    else if (v < MINV) sat_result = {1'b1, MINV[W-1:0]};
    else               sat_result = {1'b0, v[W-1:0]};
  endfunction

`ifdef PROJ_VIEWPORT_EN
  assign off_x = cx;
  assign off_y = cy;
`else
  assign off_x = {W{1'b0}};
  assign off_y = {W{1'b0}};
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign px        = $signed(xr) * $signed(dr);
  assign py        = $signed(yr) * $signed(dr);
  assign mag_x     = px[2*W-1] ? -px : px;
  assign mag_y     = py[2*W-1] ? -py : py;
  assign mag_z     = zr[W-1] ? -zr : zr;
  assign div_start = (state == MUL);
  assign z_zero    = (zr == {W{1'b0}});
  assign behind    = ($signed(zr) < NEAR_W);
  assign res_x     = sat_result(qx, px[2*W-1] ^ zr[W-1], off_x);
  assign res_y     = sat_result(qy, py[2*W-1] ^ zr[W-1], off_y);

  proj_div #(.W(W)) u_div_x (
    .clk(clk), .rst(rst), .start(div_start), .dividend(mag_x), .divisor(mag_z),
    .quotient(qx), .done(done_x)
  );

  proj_div #(.W(W)) u_div_y (
    .clk(clk), .rst(rst), .start(div_start), .dividend(mag_y), .divisor(mag_z),
    .quotient(qy), .done(done_y)
  );

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      xr        <= {W{1'b0}};
      yr        <= {W{1'b0}};
      zr        <= {W{1'b0}};
      dr        <= {W{1'b0}};
      out_valid <= 1'b0;
      ox        <= {W{1'b0}};
      oy        <= {W{1'b0}};
      flags     <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= x;
            yr    <= y;
            zr    <= z;
            dr    <= d;
            state <= MUL;
          end
        end
        MUL: state <= DIV;
        DIV: begin
          if (done_x && done_y) begin
            state             <= OUT;
            out_valid         <= 1'b1;
            ox                <= z_zero ? {W{1'b0}} : res_x[W-1:0];
            oy                <= z_zero ? {W{1'b0}} : res_y[W-1:0];
            flags[FLG_DIVZ]   <= z_zero;
            flags[FLG_BEHIND] <= behind;
            flags[FLG_SAT]    <= !z_zero && (res_x[W] || res_y[W]);
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ox        <= {W{1'b0}};
            oy        <= {W{1'b0}};
            flags     <= 3'b000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perspective_projector.sv
// Self-checking bench: directed and random vertices against an integer-division reference model.
module tb_perspective_projector;

  localparam int W = 32;
  localparam int LAT = 2 * W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] x, y, z, d, ox, oy;
  logic [2:0] flags;
  logic in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] x16, y16, z16, d16, ox16, oy16;
  logic [2:0] flags16;
`ifdef PROJ_VIEWPORT_EN
  logic [W-1:0] cx, cy;
  logic [15:0] cx16, cy16;
  localparam bit VP = 1'b1;
`else
  localparam bit VP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  perspective_projector #(.W(W), .NEAR(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .d(d),
`ifdef PROJ_VIEWPORT_EN
    .cx(cx), .cy(cy),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .ox(ox), .oy(oy), .flags(flags)
  );

  perspective_projector #(.W(16), .NEAR(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .x(x16), .y(y16), .z(z16), .d(d16),
`ifdef PROJ_VIEWPORT_EN
    .cx(cx16), .cy(cy16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16), .ox(ox16), .oy(oy16), .flags(flags16)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clip(input longint v, input int w, output bit s);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    s = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference: exact product, truncating signed division, optional offset, clamp.
  task automatic model(input int xi, yi, zi, di, cxi, cyi, output longint ex, ey,
                       output logic [2:0] ef);
    bit sx, sy;
    longint qx, qy;
    ef = 3'b000;
    ef[1] = (zi < 1);
    if (zi == 0) begin
      ex = 0; ey = 0; ef[0] = 1'b1;
    end else begin
      qx = (longint'(xi) * longint'(di)) / longint'(zi);
      qy = (longint'(yi) * longint'(di)) / longint'(zi);
      if (VP) begin
        qx = qx + longint'(cxi);
        qy = qy + longint'(cyi);
      end
      ex = clip(qx, W, sx);
      ey = clip(qy, W, sy);
      ef[2] = sx | sy;
    end
  endtask

  task automatic send(input string tag, input int xi, yi, zi, di, cxi, cyi, input int hold);
    longint ex, ey;
    logic [2:0] ef, fl_hold;
    logic [W-1:0] ox_hold, oy_hold;
    int n, lat;
    model(xi, yi, zi, di, cxi, cyi, ex, ey, ef);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, longint'(in_ready), 1);
    in_valid = 1'b1; x = xi; y = yi; z = zi; d = di;
`ifdef PROJ_VIEWPORT_EN
    cx = cxi; cy = cyi;
`endif
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      x = $urandom; y = $urandom; z = $urandom; d = $urandom;
`ifdef PROJ_VIEWPORT_EN
      cx = $urandom; cy = $urandom;
`endif
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_ox"}, longint'($signed(ox)), ex);
    check({tag, "_oy"}, longint'($signed(oy)), ey);
    check({tag, "_flags"}, longint'(flags), longint'(ef));
    ox_hold = ox; oy_hold = oy; fl_hold = flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_stable"}, longint'({out_valid, ox, oy, flags}),
            longint'({1'b1, ox_hold, oy_hold, fl_hold}));
      check({tag, "_hold_ready"}, longint'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, longint'({out_valid, flags, in_ready}), longint'(4'b0001));
  endtask

  initial begin
    bit seen;
    int n, mode, rx, ry, rz, rd;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; z = '0; d = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0;
    x16 = '0; y16 = '0; z16 = '0; d16 = '0;
`ifdef PROJ_VIEWPORT_EN
    cx = '0; cy = '0; cx16 = '0; cy16 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", longint'({out_valid, ox, oy, flags, in_ready}), 0);
    rst = 1'b0;

    send("v1", 35, 40, 800, 600, 0, 0, 0);
    send("v2", 10, 20, 650, 600, 0, 0, 0);
    send("v3", 30, 60, 1000, 600, 0, 0, 2);
    send("neg_x", -35, 40, 800, 600, 0, 0, 0);
    send("behind", 35, 40, -800, 600, 0, 0, 0);
    send("z_zero", 5, 5, 0, 600, 0, 0, 0);
    send("hold10", 123, -77, 9, 600, 0, 0, 10);
    send("sat32", 2147483647, -2147483647, 1, 2147483647, 0, 0, 1);
`ifdef PROJ_VIEWPORT_EN
    send("viewport", 35, 40, 800, 600, 320, 240, 0);
`endif

    // Reset in the middle of a division discards the vertex.
    @(negedge clk);
    in_valid = 1'b1; x = 100; y = 100; z = 500; d = 600;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("mid_rst_state", longint'({out_valid, in_ready, flags}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_output", longint'(seen), 0);
    send("after_rst", 35, 40, 800, 600, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      mode = $urandom_range(0, 2);
      rx = $urandom; ry = $urandom; rd = $urandom;
      rz = $urandom;
      if (mode == 0) begin
        rx = int'($urandom_range(0, 6000)) - 3000;
        ry = int'($urandom_range(0, 6000)) - 3000;
        rz = int'($urandom_range(0, 10000)) - 5000;
        rd = int'($urandom_range(1, 2000));
      end else if (mode == 1) begin
        rz = int'($urandom_range(0, 8)) - 4;
      end
      send($sformatf("rand%0d", i), rx, ry, rz, rd, int'($urandom_range(0, 2000)) - 1000,
           int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 3)));
    end

    // 16-bit instance saturation.
    @(negedge clk);
    in_valid16 = 1'b1; x16 = 16'sd32767; y16 = -16'sd32767; z16 = 16'sd1; d16 = 16'sd32767;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("w16_latency", n, 33);
    check("w16_ox", longint'($signed(ox16)), 32767);
    check("w16_oy", longint'($signed(oy16)), -32768);
    check("w16_flags", longint'(flags16), 4);
    @(negedge clk);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check("w16_release", longint'({out_valid16, in_ready16}), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perspective_projector.md
PERSPECTIVE_PROJECTOR -- requirements
Module: perspective_projector

Interface
REQ-001 Parameter W, 32: signed width of coordinates, focal distance and results.
REQ-002 Parameter NEAR, 1: smallest z treated as in front of the eye; z < NEAR sets the behind flag.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  vertex offered.
REQ-006 in_ready  output  1  block can accept a vertex.
REQ-007 x, y, z  input  W each  signed eye-space vertex.
REQ-008 d  input  W  signed focal distance, sampled together with the vertex.
REQ-009 out_valid  output  1  projected result held.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 ox, oy  output  W each  signed projected coordinates.
REQ-012 flags  output  3  bit0 div_zero, bit1 behind, bit2 sat.

Function
REQ-013 States: IDLE, MUL, DIV, OUT. in_ready = (state==IDLE) && !rst.
REQ-014 Vertex handshake: a vertex is accepted on an edge with in_valid && in_ready. That edge captures x, y, z, d and moves IDLE->MUL.
REQ-015 MUL: form the 2W-bit products x*d and y*d; one edge later move to DIV with the iteration counter cleared.
REQ-016 DIV: two proj_div instances run in parallel, one bit per edge, for exactly 2W edges; the last of these edges moves to OUT.
REQ-017 Division operates on magnitudes. The quotient sign is sign(product) XOR sign(z). Truncate toward zero.
REQ-018 Latency is fixed: out_valid rises 2W+1 edges after the accepting edge (65 for W=32), independent of data.
REQ-019 OUT: ox, oy and flags stay stable while out_valid=1 && out_ready=0. The edge with out_ready=1 returns to IDLE and clears out_valid.
REQ-020 Throughput is at most one vertex per 2W+2 edges; no overlapped vertices.
REQ-021 z==0: ox=oy=0 and div_zero=1. Latency is unchanged (divider runs but its result is discarded).
REQ-022 z<NEAR: behind=1; the result is still computed normally (for z!=0).
REQ-023 A quotient outside the W-bit signed range saturates to +(2^(W-1)-1) or -2^(W-1), and sat=1.
REQ-024 Flags are valid only while out_valid=1; they are cleared on the return to IDLE.
REQ-025 in_valid while busy is ignored (no capture). Input changes after acceptance have no effect.

Reset
REQ-026 rst high, at any time including mid-DIV or OUT: state=IDLE, out_valid=0, ox=oy=0, flags=0, counter=0. The in-flight vertex is discarded.
REQ-027 First acceptance is possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro PROJ_VIEWPORT_EN defined: add inputs cx, cy (W-bit signed). Results become quotient+cx and quotient+cy, added in the DIV->OUT edge, saturated per REQ-023 with sat=1.
REQ-029 PROJ_VIEWPORT_EN undefined: no cx/cy ports; outputs are raw quotients. Latency is identical in both builds.

Structure
REQ-030 Package proj_pkg holds the state enum, flag bit indices (FLG_DIVZ=0, FLG_BEHIND=1, FLG_SAT=2) and default W/NEAR constants.
REQ-031 Sub-module proj_div is an iterative unsigned restoring divider: 2W-bit dividend, W-bit divisor, start/done. It is instantiated twice (x and y) and shares the divisor |z|.

Verification
REQ-032 W=32, d=600; vertices (35,40,800), (10,20,650), (30,60,1000) -> (26,30), (9,18), (18,36); flags=0; each out_valid exactly 65 edges after its acceptance.
REQ-033 (-35,40,800), d=600 -> (-26,30) (truncation toward zero); (35,40,-800) -> (-26,-30) with behind=1.
REQ-034 (5,5,0), d=600 -> (0,0), div_zero=1, behind=1, latency 65.
REQ-035 W=16, (32767,-32767,1), d=32767 -> (32767,-32768), sat=1.
REQ-036 Hold out_ready low 10 edges in OUT -> ox/oy/flags stable and in_ready=0. Pulse rst at edge 20 of DIV -> out_valid never rises; the next vertex returns the correct result.
REQ-037 PROJ_VIEWPORT_EN, cx=320, cy=240, (35,40,800), d=600 -> (346,270).
